// File: rtl/irq_controller_if.sv
// irq_controller_if: CPU data-bus port of the interrupt controller (clk_en, cs, rw, addr, din, dout)
interface irq_controller_if;
  logic       clk_en;
  logic       cs;
  logic       rw;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  modport master (output clk_en, cs, rw, addr, din, input dout);
  modport slave  (input clk_en, cs, rw, addr, din, output dout);
endinterface

// File: rtl/irq_controller.sv
// irq_controller: AK6502 interrupt controller, NSRC edge-triggered IRQ sources plus one NMI; define IRQC_SYNC_EN to add two-flop input synchronizers
module irq_controller #(
  parameter int NSRC = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  irq_controller_if.slave  bus,
  input  logic [NSRC-1:0]  src,
  input  logic             nmi_src,
  input  logic             nmi_ack,
  output logic             irq_n,
  output logic             nmi_n
);
  localparam logic [7:0] VALID = 8'((9'd1 << NSRC) - 9'd1);
  logic [8:0] raw, smp, rise;
  logic [8:0] hist_q, hist_d;
  logic [7:0] pend_q, pend_d, mask_q, mask_d, act;
  logic       gie_q, gie_d, nmi_pend_q, nmi_pend_d, irq_n_q, irq_n_d, nmi_n_q, nmi_n_d;
  logic       we;
  logic [2:0] idx;
  assign raw = {nmi_src, 8'(src)};
`ifdef IRQC_SYNC_EN
  logic [8:0] s1_q, s2_q;
  // two-flop synchronizer; resets high so inputs already high are not seen as edges
  always_ff @(posedge clk)
    if (!rst_n) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
    end
  assign smp = s2_q;
`else
  assign smp = raw;
`endif
  // next-state: edge capture, bus writes, NMI retire and registered CPU lines
  always_comb begin
    we         = bus.cs & ~bus.rw & bus.clk_en;
    rise       = smp & ~hist_q;
    hist_d     = smp;
    pend_d     = ((we && bus.addr == 2'd0) ? pend_q & ~bus.din : pend_q) | (rise[7:0] & VALID);
    mask_d     = (we && bus.addr == 2'd1) ? bus.din & VALID : mask_q;
    gie_d      = (we && bus.addr == 2'd3) ? bus.din[0] : gie_q;
    nmi_pend_d = rise[8] | (nmi_pend_q & ~(bus.clk_en & nmi_ack));
    irq_n_d    = ~(gie_q & |(pend_q & mask_q));
    nmi_n_d    = ~nmi_pend_q;
  end
  // lowest-index enabled pending source and read mux
  always_comb begin
    act = pend_q & mask_q;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) if (act[i]) idx = 3'(i);
    bus.dout = !(bus.cs & bus.rw) ? 8'h00 :
               bus.addr == 2'd0 ? pend_q :
               bus.addr == 2'd1 ? mask_q :
               bus.addr == 2'd2 ? {|act, 4'b0, idx} :
               {nmi_pend_q, 6'b0, gie_q};
  end
  // state registers; history resets to ones so held-high sources do not fire
  always_ff @(posedge clk)
    if (!rst_n) begin
      hist_q     <= '1;
      pend_q     <= '0;
      mask_q     <= '0;
      gie_q      <= 1'b0;
      nmi_pend_q <= 1'b0;
      irq_n_q    <= 1'b1;
      nmi_n_q    <= 1'b1;
    end else begin
      hist_q     <= hist_d;
      pend_q     <= pend_d;
      mask_q     <= mask_d;
      gie_q      <= gie_d;
      nmi_pend_q <= nmi_pend_d;
      irq_n_q    <= irq_n_d;
      nmi_n_q    <= nmi_n_d;
    end
  assign irq_n = irq_n_q;
  assign nmi_n = nmi_n_q;
endmodule
